wire_alu_bank: RTL and testbench
================================

Name: wire_alu_bank

Overview:
- Parametrised successor to the single-adder wire-in/wire-out datapath: NCH independent channel pairs of WIDTH-bit operands from host wire-ins.
- One shared adder/subtractor processes the channels serially after a host trigger.
- Results are published to wire-outs as one coherent snapshot, with per-channel carry/borrow, a done pulse, a transaction counter and an overrun flag.
- Sits between the okWireIn/okTriggerIn endpoints and the okWireOut endpoints on okClk.

Parameters:
- NCH, 4, number of channels (1..16).
- WIDTH, 32, operand/result width per channel (8..32).
- CW, 8, transaction counter width.

Ports:
- okClk  input  1  host-interface clock; all logic is on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- trig  input  1  single-cycle start pulse from a trigger-in.
- op_mode  input  2  00 add, 01 subtract, 10 accumulate, 11 clear.
- operand_a  input  NCH*WIDTH  channel k at bits [k*WIDTH +: WIDTH].
- operand_b  input  NCH*WIDTH  same packing as operand_a.
- result  output  NCH*WIDTH  published results, same packing.
- carry  output  NCH  per-channel carry-out (add/acc) or borrow (sub).
- busy  output  1  high while a transaction is in progress.
- done  output  1  one-cycle pulse when the snapshot is published.
- overrun  output  1  sticky flag: a trigger arrived while busy.
- seq_count  output  CW  count of completed transactions; wraps modulo 2^CW.

Behaviour:
- Reset (asynchronous, active-high): state IDLE, result=0, carry=0, busy=0, done=0, overrun=0, seq_count=0, channel index=0. Shadow registers and latched operands are cleared.
- Reset asserted mid-transaction aborts it. No done pulse, no publish, seq_count unchanged from reset value 0.
- States:
  - IDLE: if trig=1, latch operand_a, operand_b and op_mode into internal registers, clear overrun, set ch=0, go to RUN. busy rises on the same edge.
  - RUN: each cycle computes channel ch into shadow[ch] and shadow_c[ch], then ch increments. On the cycle ch=NCH-1, go to PUB.
  - PUB: copy shadow to result and shadow_c to carry, assert done for this one cycle, increment seq_count, deassert busy, go to IDLE.
- Latency: trig sampled at edge T. busy=1 from T through T+NCH. result, carry and done update at edge T+NCH+1. busy=0 and IDLE are reached at that same edge.
- Back-to-back transactions: a trig sampled in the cycle after done is accepted.
- Arithmetic, computed at WIDTH+1 bits. Channel k uses the latched a[k] and b[k].
  - add: {c,r} = a + b.
  - sub: r = a - b mod 2^WIDTH; c = 1 if a < b, unsigned.
  - acc: {c,r} = result[k] + a[k], where result[k] is the published value before this transaction; b is ignored.
  - clear: r = 0, c = 0.
- Operand inputs may change during RUN without effect, because only the latched copies are used.
- trig while busy (RUN or PUB): ignored, overrun set to 1. overrun holds until the next accepted trig, which clears it on the accepting edge.
- result and carry never show partial updates; all channels change on the same edge.
- seq_count wraps from 2^CW-1 to 0 without a flag.

Test Plan:
- Reset with NCH=4, WIDTH=32, then trig, add, a={1,2,3,4}, b={10,20,30,40} -> done at trig+5 cycles; result={11,22,33,44}; carry=0; seq_count=1; busy high for exactly 5 cycles.
- Add a0=FFFFFFFF, b0=1; sub a1=5, b1=7 (separate runs) -> add run: r0=0, carry[0]=1. Sub run: r1=FFFFFFFE, carry[1]=1.
- Accumulate with a={1,1,1,1} triggered 3 times back-to-back after a clear -> results {3,3,3,3}; seq_count advances by 4 (clear + 3 acc); no overrun.
- trig pulsed again 2 cycles after an accepted trig -> overrun=1; only one done; overrun clears on the next accepted trig.
- operand_a changed and reset asserted at RUN cycle 2 -> outputs all 0 immediately (async); no done; a fresh trig then completes normally.
- CW=2 bench, 5 transactions -> seq_count sequence 1,2,3,0,1.

Source files
------------

// File: rtl/wire_alu_bank.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : wire_alu_bank                                                   |
// | Purpose  : Bank of NCH add/sub/accumulate/clear channels sharing a single  |
// |            WIDTH+1 bit adder. After a host trigger the operands are        |
// |            latched, the channels are processed one per cycle into a       |
// |            shadow bank, and the whole bank is published to the wire-outs  |
// |            on a single edge together with a done pulse.                    |
// | Ports    : okClk      - host-interface clock, rising edge                  |
// |            reset      - asynchronous active-high reset                     |
// |            trig       - single-cycle start pulse                           |
// |            op_mode    - 00 add, 01 sub, 10 accumulate, 11 clear            |
// |            operand_a  - NCH x WIDTH packed operands, channel k at k*WIDTH  |
// |            operand_b  - same packing as operand_a                          |
// |            result     - published results, same packing                    |
// |            carry      - per-channel carry-out (add/acc) or borrow (sub)    |
// |            busy       - transaction in progress                            |
// |            done       - one-cycle pulse when a snapshot is published       |
// |            overrun    - sticky: trigger seen while busy                    |
// |            seq_count  - completed-transaction counter, wraps silently      |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module wire_alu_bank #(
  parameter int NCH   = 4,
  parameter int WIDTH = 32,
  parameter int CW    = 8
) (
  input  logic                   okClk,
  input  logic                   reset,
  input  logic                   trig,
  input  logic [1:0]             op_mode,
  input  logic [NCH*WIDTH-1:0]   operand_a,
  input  logic [NCH*WIDTH-1:0]   operand_b,
  output logic [NCH*WIDTH-1:0]   result,
  output logic [NCH-1:0]         carry,
  output logic                   busy,
  output logic                   done,
  output logic                   overrun,
  output logic [CW-1:0]          seq_count
);

  // Channel index needs at least one bit even for a single-channel bank.
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CHW-1:0] LAST_CH = CHW'(NCH - 1);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_ACC = 2'b10;
  localparam logic [1:0] OP_CLR = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_PUB  = 2'd2
  } state_t;

  state_t                 state_q,    state_d;
  logic [CHW-1:0]         ch_q,       ch_d;
  logic [1:0]             op_q,       op_d;
  logic [NCH*WIDTH-1:0]   a_q,        a_d;
  logic [NCH*WIDTH-1:0]   b_q,        b_d;
  logic [NCH*WIDTH-1:0]   shadow_q,   shadow_d;
  logic [NCH-1:0]         shadow_c_q, shadow_c_d;
  logic [NCH*WIDTH-1:0]   result_q,   result_d;
  logic [NCH-1:0]         carry_q,    carry_d;
  logic                   busy_q,     busy_d;
  logic                   done_q,     done_d;
  logic                   overrun_q,  overrun_d;
  logic [CW-1:0]          seq_q,      seq_d;

  // Shared arithmetic unit operands for the channel currently selected.
  logic [WIDTH-1:0]       ch_a;
  logic [WIDTH-1:0]       ch_b;
  logic [WIDTH-1:0]       ch_prev;
  logic [WIDTH:0]         ch_sum;

  always_comb begin
    ch_a    = a_q[int'(ch_q)*WIDTH +: WIDTH];
    ch_b    = b_q[int'(ch_q)*WIDTH +: WIDTH];
    // Accumulate reads the published bank, which stays frozen until PUB,
    // so every channel sees its value from before this transaction.
    ch_prev = result_q[int'(ch_q)*WIDTH +: WIDTH];
    ch_sum  = '0;
    case (op_q)
      OP_ADD:  ch_sum = {1'b0, ch_a} + {1'b0, ch_b};
      // With both operands zero-extended, bit WIDTH of the difference is
      // set exactly when a < b, which is the borrow.
      OP_SUB:  ch_sum = {1'b0, ch_a} - {1'b0, ch_b};
      OP_ACC:  ch_sum = {1'b0, ch_prev} + {1'b0, ch_a};
      OP_CLR:  ch_sum = '0;
      default: ch_sum = '0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    ch_d       = ch_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    shadow_d   = shadow_q;
    shadow_c_d = shadow_c_q;
    result_d   = result_q;
    carry_d    = carry_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    overrun_d  = overrun_q;
    seq_d      = seq_q;

    case (state_q)
      S_IDLE: begin
        if (trig) begin
          a_d       = operand_a;
          b_d       = operand_b;
          op_d      = op_mode;
          ch_d      = '0;
          overrun_d = 1'b0;
          busy_d    = 1'b1;
          state_d   = S_RUN;
        end
      end

      S_RUN: begin
        if (trig) begin
          overrun_d = 1'b1;
        end
        shadow_d[int'(ch_q)*WIDTH +: WIDTH] = ch_sum[WIDTH-1:0];
        shadow_c_d[ch_q]                     = ch_sum[WIDTH];
        if (ch_q == LAST_CH) begin
          ch_d    = '0;
          state_d = S_PUB;
        end else begin
          ch_d    = ch_q + 1'b1;
        end
      end

      S_PUB: begin
        if (trig) begin
          overrun_d = 1'b1;
        end
        // Whole bank moves on one edge so the host never reads a mix of
        // old and new channels.
        result_d = shadow_q;
        carry_d  = shadow_c_q;
        done_d   = 1'b1;
        seq_d    = seq_q + 1'b1;
        busy_d   = 1'b0;
        state_d  = S_IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge okClk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      ch_q       <= '0;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      shadow_q   <= '0;
      shadow_c_q <= '0;
      result_q   <= '0;
      carry_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      overrun_q  <= 1'b0;
      seq_q      <= '0;
    end else begin
      state_q    <= state_d;
      ch_q       <= ch_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      shadow_q   <= shadow_d;
      shadow_c_q <= shadow_c_d;
      result_q   <= result_d;
      carry_q    <= carry_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      overrun_q  <= overrun_d;
      seq_q      <= seq_d;
    end
  end

  assign result    = result_q;
  assign carry     = carry_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign overrun   = overrun_q;
  assign seq_count = seq_q;

endmodule
`default_nettype wire

// File: tb/tb_wire_alu_bank.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_wire_alu_bank                                                |
// | Purpose  : Self-checking bench for wire_alu_bank: directed vector table,   |
// |            randomized transactions against a behavioural model, overrun,  |
// |            asynchronous abort, and a narrow CW=2 instance for wrap-around. |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_wire_alu_bank;

  localparam int NCH   = 4;
  localparam int WIDTH = 32;
  localparam int CW    = 8;
  localparam int W     = NCH * WIDTH;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset;
  logic             trig;
  logic [1:0]       op_mode;
  logic [W-1:0]     operand_a;
  logic [W-1:0]     operand_b;
  logic [W-1:0]     result;
  logic [NCH-1:0]   carry;
  logic             busy;
  logic             done;
  logic             overrun;
  logic [CW-1:0]    seq_count;

  // Narrow instance: one 8-bit channel, 2-bit counter.
  logic             s_trig;
  logic [1:0]       s_op;
  logic [7:0]       s_a;
  logic [7:0]       s_b;
  logic [7:0]       s_result;
  logic [0:0]       s_carry;
  logic             s_busy;
  logic             s_done;
  logic             s_overrun;
  logic [1:0]       s_seq;

  wire_alu_bank #(.NCH(NCH), .WIDTH(WIDTH), .CW(CW)) dut (
    .okClk(clk), .reset(reset), .trig(trig), .op_mode(op_mode),
    .operand_a(operand_a), .operand_b(operand_b), .result(result),
    .carry(carry), .busy(busy), .done(done), .overrun(overrun),
    .seq_count(seq_count)
  );

  wire_alu_bank #(.NCH(1), .WIDTH(8), .CW(2)) dut_small (
    .okClk(clk), .reset(reset), .trig(s_trig), .op_mode(s_op),
    .operand_a(s_a), .operand_b(s_b), .result(s_result),
    .carry(s_carry), .busy(s_busy), .done(s_done), .overrun(s_overrun),
    .seq_count(s_seq)
  );

  int total = 0;
  int bad   = 0;

  // Behavioural model state.
  logic [WIDTH-1:0] m_res [NCH];
  logic             m_c   [NCH];
  logic [CW-1:0]    m_seq;
  logic             m_ovr;

  typedef struct {
    logic [1:0]     op;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [W-1:0]   er;
    logic [NCH-1:0] ec;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NCH; k++) begin
      m_res[k] = '0;
      m_c[k]   = 1'b0;
    end
    m_seq = '0;
    m_ovr = 1'b0;
  endtask

  // Runs one transaction starting #1 after a rising edge. A non-negative
  // glitch pulses trig again that many cycles after the accepting edge.
  // Operand and mode inputs are scrambled while the bank is busy.
  task automatic run_txn(input logic [1:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input int glitch);
    logic [WIDTH:0]   s;
    logic [WIDTH-1:0] x, y;
    logic [W-1:0]     er;
    logic [NCH-1:0]   ec;
    int lat, bcnt;
    bit seen;
    for (int k = 0; k < NCH; k++) begin
      x = a[k*WIDTH +: WIDTH];
      y = b[k*WIDTH +: WIDTH];
      case (op)
        2'b00:   s = {1'b0, x} + {1'b0, y};
        2'b01:   s = {(x < y), x - y};
        2'b10:   s = {1'b0, m_res[k]} + {1'b0, x};
        default: s = '0;
      endcase
      m_res[k] = s[WIDTH-1:0];
      m_c[k]   = s[WIDTH];
    end
    m_seq = m_seq + 1'b1;
    m_ovr = (glitch >= 0);

    trig = 1'b1; op_mode = op; operand_a = a; operand_b = b;
    @(posedge clk); #1;
    trig = 1'b0;
    chk("busy_rise", W'(busy), W'(1));
    chk("ovr_clear_on_accept", W'(overrun), W'(0));
    lat = 0; bcnt = 0; seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      operand_a = {$urandom, $urandom, $urandom, $urandom};
      operand_b = {$urandom, $urandom, $urandom, $urandom};
      op_mode   = 2'($urandom);
      trig      = (i == glitch);
      if (busy) bcnt++;
      @(posedge clk); #1;
      lat++;
      if (done) seen = 1'b1;
    end
    trig = 1'b0;
    chk("done_seen", W'(seen), W'(1));
    chk("latency", W'(lat), W'(NCH + 1));
    chk("busy_cycles", W'(bcnt), W'(NCH + 1));
    chk("busy_fall", W'(busy), W'(0));
    for (int k = 0; k < NCH; k++) begin
      er[k*WIDTH +: WIDTH] = m_res[k];
      ec[k]                = m_c[k];
    end
    chk("result", result, er);
    chk("carry", W'(carry), W'(ec));
    chk("seq_count", W'(seq_count), W'(m_seq));
    chk("overrun", W'(overrun), W'(m_ovr));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dcnt;
    logic [8:0] ss;
    logic [7:0] sa;

    tbl[0] = '{2'b00, {32'd4, 32'd3, 32'd2, 32'd1}, {32'd40, 32'd30, 32'd20, 32'd10},
               {32'd44, 32'd33, 32'd22, 32'd11}, 4'b0000};
    tbl[1] = '{2'b00, {32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF}, {32'd0, 32'd0, 32'd0, 32'd1},
               {32'd0, 32'd0, 32'd0, 32'd0}, 4'b0001};
    tbl[2] = '{2'b01, {32'd0, 32'd0, 32'd5, 32'd0}, {32'd0, 32'd0, 32'd7, 32'd0},
               {32'd0, 32'd0, 32'hFFFF_FFFE, 32'd0}, 4'b0010};
    tbl[3] = '{2'b11, {32'd9, 32'd8, 32'd7, 32'd6}, {32'd1, 32'd2, 32'd3, 32'd4},
               {32'd0, 32'd0, 32'd0, 32'd0}, 4'b0000};
    tbl[4] = '{2'b10, {32'd1, 32'd1, 32'd1, 32'd1}, {4{32'hDEAD_BEEF}},
               {32'd1, 32'd1, 32'd1, 32'd1}, 4'b0000};
    tbl[5] = '{2'b10, {32'd1, 32'd1, 32'd1, 32'd1}, {4{32'hDEAD_BEEF}},
               {32'd2, 32'd2, 32'd2, 32'd2}, 4'b0000};
    tbl[6] = '{2'b10, {32'd1, 32'd1, 32'd1, 32'd1}, {4{32'hDEAD_BEEF}},
               {32'd3, 32'd3, 32'd3, 32'd3}, 4'b0000};
    tbl[7] = '{2'b00, {4{32'h8000_0000}}, {4{32'h8000_0000}},
               {32'd0, 32'd0, 32'd0, 32'd0}, 4'b1111};

    reset = 1'b1; trig = 1'b0; op_mode = '0; operand_a = '0; operand_b = '0;
    s_trig = 1'b0; s_op = '0; s_a = '0; s_b = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_result", result, '0);
    chk("rst_carry", W'(carry), '0);
    chk("rst_busy", W'(busy), '0);
    chk("rst_done", W'(done), '0);
    chk("rst_overrun", W'(overrun), '0);
    chk("rst_seq", W'(seq_count), '0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Directed table, back-to-back.
    for (int i = 0; i < 8; i++) begin
      run_txn(tbl[i].op, tbl[i].a, tbl[i].b, -1);
      chk("tbl_result", result, tbl[i].er);
      chk("tbl_carry", W'(carry), W'(tbl[i].ec));
    end
    chk("tbl_seq", W'(seq_count), W'(8));

    // Randomized transactions.
    for (int i = 0; i < 24; i++) begin
      run_txn(2'($urandom),
              {$urandom, $urandom, $urandom, $urandom},
              {$urandom, $urandom, $urandom, $urandom}, -1);
    end

    // Extra trigger while busy: sticky overrun, single done.
    run_txn(2'b00, {32'd4, 32'd3, 32'd2, 32'd1}, {32'd40, 32'd30, 32'd20, 32'd10}, 1);
    dcnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (done) dcnt++;
    end
    chk("overrun_single_done", W'(dcnt), W'(0));
    chk("overrun_sticky", W'(overrun), W'(1));
    chk("overrun_no_restart", W'(busy), W'(0));
    run_txn(2'b00, {32'd4, 32'd3, 32'd2, 32'd1}, {32'd40, 32'd30, 32'd20, 32'd10}, -1);

    // Abort with asynchronous reset in the middle of a run.
    trig = 1'b1; op_mode = 2'b00;
    operand_a = {4{32'h1234_5678}}; operand_b = {4{32'h1111_1111}};
    @(posedge clk); #1;
    trig = 1'b0;
    @(posedge clk); #1;
    operand_a = {4{32'hCAFE_F00D}};
    #2 reset = 1'b1;
    #1;
    chk("abort_result", result, '0);
    chk("abort_carry", W'(carry), '0);
    chk("abort_busy", W'(busy), '0);
    chk("abort_seq", W'(seq_count), '0);
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    dcnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (done) dcnt++;
    end
    chk("abort_no_done", W'(dcnt), W'(0));
    chk("abort_seq_hold", W'(seq_count), '0);
    run_txn(2'b00, {32'd5, 32'd6, 32'd7, 32'd8}, {32'd1, 32'd1, 32'd1, 32'hFFFF_FFFF}, -1);

    // Narrow instance: counter wraps 1,2,3,0,1; 8-bit carry.
    for (int i = 0; i < 5; i++) begin
      sa = 8'((i * 60 + 100) % 256);
      ss = {1'b0, sa} + 9'd90;
      s_trig = 1'b1; s_op = 2'b00; s_a = sa; s_b = 8'd90;
      @(posedge clk); #1;
      s_trig = 1'b0;
      dcnt = 0;
      for (int j = 0; j < 20 && !s_done; j++) begin
        @(posedge clk); #1;
        dcnt++;
      end
      chk("small_latency", W'(dcnt), W'(2));
      chk("small_seq", W'(s_seq), W'((i + 1) % 4));
      chk("small_result", W'(s_result), W'(ss[7:0]));
      chk("small_carry", W'(s_carry), W'(ss[8]));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
